// File: rtl/exc_commit_ctrl_pkg.sv
// Shared exception/commit definitions for the write-back commit controller.
// Interrupt support is enabled with the EXC_INT_EN macro (see exc_commit_ctrl.sv).
package exc_commit_ctrl_pkg;

    localparam logic [5:0] ECODE_INT     = 6'h00;
    localparam logic [5:0] ECODE_ADE     = 6'h08;
    localparam logic [5:0] ECODE_ALE     = 6'h09;
    localparam logic [5:0] ECODE_SYS     = 6'h0B;
    localparam logic [5:0] ECODE_BRK     = 6'h0C;
    localparam logic [5:0] ECODE_INE     = 6'h0D;
    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;

    // ws_op = {csrxchg, csrwr, csrrd, ertn}
    localparam int unsigned OP_ERTN    = 0;
    localparam int unsigned OP_CSRRD   = 1;
    localparam int unsigned OP_CSRWR   = 2;
    localparam int unsigned OP_CSRXCHG = 3;

    // ws_exc = {ale, brk, sys, ine, adef}
    localparam int unsigned EXC_ADEF = 0;
    localparam int unsigned EXC_INE  = 1;
    localparam int unsigned EXC_SYS  = 2;
    localparam int unsigned EXC_BRK  = 3;
    localparam int unsigned EXC_ALE  = 4;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

endpackage

// File: rtl/exc_commit_ctrl_prio.sv
// Exception priority encoder: INT > ADEF > INE > SYS > BRK > ALE.
module exc_prio_enc
    import exc_commit_ctrl_pkg::*;
(
    input  logic       int_q,
    input  logic [4:0] exc,
    output logic       hit,
    output logic [5:0] ecode,
    output logic [8:0] esubcode
);

    always_comb begin
        hit      = 1'b1;
        ecode    = '0;
        esubcode = '0;
        if (int_q) begin
            ecode = ECODE_INT;
        end else if (exc[EXC_ADEF]) begin
            ecode    = ECODE_ADE;
            esubcode = ESUBCODE_ADEF;
        end else if (exc[EXC_INE]) begin
            ecode = ECODE_INE;
        end else if (exc[EXC_SYS]) begin
            ecode = ECODE_SYS;
        end else if (exc[EXC_BRK]) begin
            ecode = ECODE_BRK;
        end else if (exc[EXC_ALE]) begin
            ecode = ECODE_ALE;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Write-back commit controller: drives the CSR command interface and the fetch redirect.
// Define EXC_INT_EN to enable interrupt sampling (int_pending & crmd_ie) at top priority.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter int unsigned PC_W           = 32,
    parameter int unsigned FLUSH_HOLD_MIN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ws_valid,
    output logic            ws_ready,
    input  logic [PC_W-1:0] ws_pc,
    input  logic [3:0]      ws_op,
    input  logic [4:0]      ws_exc,
    input  logic [13:0]     ws_csr_num,
    input  logic [PC_W-1:0] ws_rj,
    input  logic [PC_W-1:0] ws_rd,
    output logic [PC_W-1:0] ws_csr_result,
    input  logic            int_pending,
    input  logic            crmd_ie,
    input  logic [PC_W-1:0] csr_eentry,
    input  logic [PC_W-1:0] csr_era,
    output logic            csr_re,
    output logic            csr_we,
    output logic [13:0]     csr_num,
    output logic [PC_W-1:0] csr_wmask,
    output logic [PC_W-1:0] csr_wvalue,
    input  logic [PC_W-1:0] csr_rvalue,
    output logic            wb_ex,
    output logic            eret_flush,
    output logic [5:0]      wb_ecode,
    output logic [8:0]      wb_esubcode,
    output logic [PC_W-1:0] wb_pc,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready
);

    localparam int unsigned HCW = $clog2(FLUSH_HOLD_MIN + 1) + 1;

    state_t            state, state_nxt;
    logic              int_q;
    logic              tgt_era_q;
    logic              cap_q;
    logic [HCW-1:0]    hold_cnt;
    logic [PC_W-1:0]   pc_q;
    logic              commit;
    logic              exc_hit;
    logic [5:0]        enc_ecode;
    logic [8:0]        enc_esubcode;
    logic              hold_done;
    logic [PC_W-1:0]   redir_live;

`ifdef EXC_INT_EN
    always_ff @(posedge clk) begin
        if (reset) int_q <= 1'b0;
        else       int_q <= int_pending & crmd_ie;
    end
`else
    logic unused_int;
    assign unused_int = int_pending ^ crmd_ie;
    assign int_q      = 1'b0;
`endif

    exc_prio_enc u_prio (
        .int_q    (int_q),
        .exc      (ws_exc),
        .hit      (exc_hit),
        .ecode    (enc_ecode),
        .esubcode (enc_esubcode)
    );

    assign hold_done  = hold_cnt >= HCW'(FLUSH_HOLD_MIN);
    assign redir_live = tgt_era_q ? csr_era : csr_eentry;

    // Target is sampled live in the first REDIRECT cycle so the CSR update from the commit is visible, then held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tgt_era_q <= 1'b0;
            cap_q     <= 1'b0;
            hold_cnt  <= '0;
            pc_q      <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_REDIRECT) begin
                tgt_era_q <= eret_flush;
                cap_q     <= 1'b0;
                hold_cnt  <= HCW'(1);
            end else if (state == ST_REDIRECT) begin
                cap_q <= 1'b1;
                if (!cap_q)     pc_q     <= redir_live;
                if (!hold_done) hold_cnt <= hold_cnt + HCW'(1);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        ws_ready       = (state == ST_IDLE);
        commit         = ws_valid & ws_ready & ~reset;
        ws_csr_result  = '0;
        csr_re         = 1'b0;
        csr_we         = 1'b0;
        csr_num        = '0;
        csr_wmask      = '0;
        csr_wvalue     = '0;
        wb_ex          = 1'b0;
        eret_flush     = 1'b0;
        wb_ecode       = '0;
        wb_esubcode    = '0;
        wb_pc          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        if (commit) begin
            if (exc_hit) begin
                wb_ex       = 1'b1;
                wb_ecode    = enc_ecode;
                wb_esubcode = enc_esubcode;
                wb_pc       = ws_pc;
                state_nxt   = ST_REDIRECT;
            end else if (ws_op[OP_ERTN]) begin
                eret_flush = 1'b1;
                state_nxt  = ST_REDIRECT;
            end else if (ws_op[OP_CSRXCHG] | ws_op[OP_CSRWR] | ws_op[OP_CSRRD]) begin
                csr_re        = 1'b1;
                csr_num       = ws_csr_num;
                ws_csr_result = csr_rvalue;
                if (ws_op[OP_CSRXCHG]) begin
                    csr_we     = 1'b1;
                    csr_wmask  = ws_rj;
                    csr_wvalue = ws_rd;
                end else if (ws_op[OP_CSRWR]) begin
                    csr_we     = 1'b1;
                    csr_wmask  = '1;
                    csr_wvalue = ws_rd;
                end
            end
        end

        if (state == ST_REDIRECT) begin
            redirect_valid = 1'b1;
            redirect_pc    = cap_q ? pc_q : redir_live;
            if (redirect_ready && hold_done) state_nxt = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: vector table plus hand-written redirect/reset sequences.
module tb_exc_commit_ctrl;

    localparam logic [31:0] EENTRY = 32'h1C008000;
    localparam logic [31:0] ERA    = 32'h1C000014;
    localparam logic [31:0] RV     = 32'hAAAAAAAA;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_valid;
    logic        ws_ready;
    logic [31:0] ws_pc;
    logic [3:0]  ws_op;
    logic [4:0]  ws_exc;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_rj, ws_rd, ws_csr_result;
    logic        int_pending, crmd_ie;
    logic [31:0] csr_eentry, csr_era;
    logic        csr_re, csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue, csr_rvalue;
    logic        wb_ex, eret_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int checks = 0;
    int errors = 0;

    exc_commit_ctrl #(.PC_W(32), .FLUSH_HOLD_MIN(1)) dut (
        .clk(clk), .reset(reset),
        .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_pc(ws_pc), .ws_op(ws_op),
        .ws_exc(ws_exc), .ws_csr_num(ws_csr_num), .ws_rj(ws_rj), .ws_rd(ws_rd),
        .ws_csr_result(ws_csr_result), .int_pending(int_pending), .crmd_ie(crmd_ie),
        .csr_eentry(csr_eentry), .csr_era(csr_era), .csr_re(csr_re), .csr_we(csr_we),
        .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .csr_rvalue(csr_rvalue), .wb_ex(wb_ex), .eret_flush(eret_flush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [4:0]  exc;
        logic [31:0] pc;
        logic [13:0] num;
        logic [31:0] rj;
        logic [31:0] rd;
        logic        ex;
        logic [5:0]  ecode;
        logic        eret;
        logic        re;
        logic        we;
        logic [13:0] cnum;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic [31:0] result;
        logic [31:0] wbpc;
        logic        redir;
        logic [31:0] rpc;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ws_valid   = 1'b0;
        ws_op      = '0;
        ws_exc     = '0;
        ws_pc      = '0;
        ws_csr_num = '0;
        ws_rj      = '0;
        ws_rd      = '0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] exc, input logic [31:0] pc,
                         input logic [13:0] num, input logic [31:0] rj, input logic [31:0] rd);
        ws_valid   = 1'b1;
        ws_op      = op;
        ws_exc     = exc;
        ws_pc      = pc;
        ws_csr_num = num;
        ws_rj      = rj;
        ws_rd      = rd;
    endtask

    // Handshake out of REDIRECT with one ready cycle and confirm we are back in IDLE.
    task automatic finish_redirect(input string tag, input logic [31:0] exp_pc);
        chk({tag, "_rvalid"}, 32'(redirect_valid), 32'd1);
        chk({tag, "_rpc"}, redirect_pc, exp_pc);
        chk({tag, "_ready_lo"}, 32'(ws_ready), 32'd0);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        #1;
        chk({tag, "_rvalid_drop"}, 32'(redirect_valid), 32'd0);
        chk({tag, "_ready_hi"}, 32'(ws_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'b0000, 5'b00100, 32'h1C000010, 14'h0, 32'h0, 32'h0,
                     1'b1, 6'h0B, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 32'h1C000010, 1'b1, EENTRY};
        vecs[1]  = '{1'b1, 4'b0001, 5'b00000, 32'h1C000020, 14'h0, 32'h0, 32'h0,
                     1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, ERA};
        vecs[2]  = '{1'b1, 4'b1000, 5'b00000, 32'h1C000030, 14'h30, 32'h0000FF00, 32'h12345678,
                     1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 14'h30, 32'h0000FF00, 32'h12345678, RV, 32'h0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'b0100, 5'b10011, 32'h1C000040, 14'h1, 32'h0, 32'h0000CAFE,
                     1'b1, 6'h08, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 32'h1C000040, 1'b1, EENTRY};
        vecs[4]  = '{1'b1, 4'b0100, 5'b00000, 32'h1C000050, 14'h6, 32'h0F0F0F0F, 32'hDEADBEEF,
                     1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 14'h6, 32'hFFFFFFFF, 32'hDEADBEEF, RV, 32'h0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 4'b0010, 5'b00000, 32'h1C000054, 14'h7, 32'h1, 32'h2,
                     1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 14'h7, 32'h0, 32'h0, RV, 32'h0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 4'b0000, 5'b11000, 32'h1C000060, 14'h0, 32'h0, 32'h0,
                     1'b1, 6'h0C, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 32'h1C000060, 1'b1, EENTRY};
        vecs[7]  = '{1'b1, 4'b0000, 5'b10000, 32'h1C000064, 14'h0, 32'h0, 32'h0,
                     1'b1, 6'h09, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 32'h1C000064, 1'b1, EENTRY};
        vecs[8]  = '{1'b1, 4'b0000, 5'b00110, 32'h1C000068, 14'h0, 32'h0, 32'h0,
                     1'b1, 6'h0D, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 32'h1C000068, 1'b1, EENTRY};
        vecs[9]  = '{1'b1, 4'b0101, 5'b00000, 32'h1C00006C, 14'h9, 32'h0, 32'h11,
                     1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, ERA};
        vecs[10] = '{1'b1, 4'b0001, 5'b00100, 32'h1C000070, 14'h0, 32'h0, 32'h0,
                     1'b1, 6'h0B, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 32'h1C000070, 1'b1, EENTRY};
        vecs[11] = '{1'b0, 4'b0100, 5'b00000, 32'h1C000074, 14'h3, 32'h0, 32'h1,
                     1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 4'b0000, 5'b00000, 32'h1C000078, 14'h3, 32'h5, 32'h6,
                     1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};

        reset          = 1'b1;
        idle_in();
        int_pending    = 1'b0;
        crmd_ie        = 1'b0;
        csr_eentry     = EENTRY;
        csr_era        = ERA;
        csr_rvalue     = RV;
        redirect_ready = 1'b0;
        tick();
        tick();
        chk("rst_ws_ready", 32'(ws_ready), 32'd1);
        chk("rst_rvalid", 32'(redirect_valid), 32'd0);
        chk("rst_wb_ex", 32'(wb_ex), 32'd0);
        chk("rst_csr_we", 32'(csr_we), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            ws_valid   = vecs[i].valid;
            ws_op      = vecs[i].op;
            ws_exc     = vecs[i].exc;
            ws_pc      = vecs[i].pc;
            ws_csr_num = vecs[i].num;
            ws_rj      = vecs[i].rj;
            ws_rd      = vecs[i].rd;
            #1;
            chk({t, "_wb_ex"}, 32'(wb_ex), 32'(vecs[i].ex));
            chk({t, "_ecode"}, 32'(wb_ecode), 32'(vecs[i].ecode));
            chk({t, "_esub"}, 32'(wb_esubcode), 32'd0);
            chk({t, "_eret"}, 32'(eret_flush), 32'(vecs[i].eret));
            chk({t, "_re"}, 32'(csr_re), 32'(vecs[i].re));
            chk({t, "_we"}, 32'(csr_we), 32'(vecs[i].we));
            chk({t, "_num"}, 32'(csr_num), 32'(vecs[i].cnum));
            chk({t, "_wmask"}, csr_wmask, vecs[i].wmask);
            chk({t, "_wvalue"}, csr_wvalue, vecs[i].wvalue);
            chk({t, "_result"}, ws_csr_result, vecs[i].result);
            chk({t, "_wb_pc"}, wb_pc, vecs[i].wbpc);
            tick();
            idle_in();
            #1;
            if (vecs[i].redir) begin
                finish_redirect(t, vecs[i].rpc);
            end else begin
                chk({t, "_no_redir"}, 32'(redirect_valid), 32'd0);
            end
        end

        // SYS with delayed ready: target taken in first REDIRECT cycle, then held; WB op is flushed.
        csr_eentry = 32'h1C007000;
        drive(4'b0000, 5'b00100, 32'h1C000010, 14'h0, 32'h0, 32'h0);
        #1;
        chk("sa_wb_ex", 32'(wb_ex), 32'd1);
        chk("sa_ecode", 32'(wb_ecode), 32'h0B);
        tick();
        csr_eentry = 32'h1C008000;
        drive(4'b0100, 5'b00000, 32'h1C000014, 14'h2, 32'h0, 32'h99);
        #1;
        chk("sa_rpc_live", redirect_pc, 32'h1C008000);
        chk("sa_flush_we", 32'(csr_we), 32'd0);
        chk("sa_flush_re", 32'(csr_re), 32'd0);
        chk("sa_flush_ex", 32'(wb_ex), 32'd0);
        tick();
        csr_eentry = 32'h1C00F000;
        #1;
        chk("sa_rpc_held", redirect_pc, 32'h1C008000);
        chk("sa_rvalid_stall", 32'(redirect_valid), 32'd1);
        tick();
        chk("sa_ready_lo", 32'(ws_ready), 32'd0);
        idle_in();
        finish_redirect("sa", 32'h1C008000);
        csr_eentry = EENTRY;

        // ERTN with int_pending arriving in the same cycle.
        int_pending = 1'b1;
        crmd_ie     = 1'b1;
        drive(4'b0001, 5'b00000, 32'h1C000080, 14'h0, 32'h0, 32'h0);
        #1;
        chk("sb_eret", 32'(eret_flush), 32'd1);
        chk("sb_wb_ex", 32'(wb_ex), 32'd0);
        tick();
        int_pending = 1'b0;
        crmd_ie     = 1'b0;
        idle_in();
        #1;
        finish_redirect("sb", ERA);

        // Interrupt pending one cycle before a csrwr.
        int_pending = 1'b1;
        crmd_ie     = 1'b1;
        tick();
        int_pending = 1'b0;
        crmd_ie     = 1'b0;
        drive(4'b0100, 5'b00000, 32'h1C000090, 14'h5, 32'h0, 32'h55);
        #1;
`ifdef EXC_INT_EN
        chk("sc_wb_ex", 32'(wb_ex), 32'd1);
        chk("sc_ecode", 32'(wb_ecode), 32'h00);
        chk("sc_we", 32'(csr_we), 32'd0);
        chk("sc_wb_pc", wb_pc, 32'h1C000090);
        tick();
        idle_in();
        #1;
        finish_redirect("sc", EENTRY);
`else
        chk("sc_wb_ex", 32'(wb_ex), 32'd0);
        chk("sc_we", 32'(csr_we), 32'd1);
        chk("sc_wvalue", csr_wvalue, 32'h55);
        chk("sc_wmask", csr_wmask, 32'hFFFFFFFF);
        tick();
        idle_in();
        #1;
        chk("sc_no_redir", 32'(redirect_valid), 32'd0);
`endif

        // Reset while in REDIRECT with a held WB instruction.
        drive(4'b0000, 5'b00100, 32'h1C0000A0, 14'h0, 32'h0, 32'h0);
        tick();
        drive(4'b0100, 5'b00000, 32'h1C0000A4, 14'h4, 32'h0, 32'h77);
        #1;
        chk("sd_rvalid", 32'(redirect_valid), 32'd1);
        reset = 1'b1;
        tick();
        #1;
        chk("sd_rvalid_rst", 32'(redirect_valid), 32'd0);
        chk("sd_ready_rst", 32'(ws_ready), 32'd1);
        chk("sd_we_rst", 32'(csr_we), 32'd0);
        chk("sd_re_rst", 32'(csr_re), 32'd0);
        reset = 1'b0;
        idle_in();
        tick();
        chk("sd_rvalid_after", 32'(redirect_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
